arith_sequencer: RTL and testbench

//  Instruction-level controller for arith_machine. Accepts 32-bit MIPS R/I-type ALU

---
 rtl/arith_sequencer_pkg.sv | 73 +++++++
 rtl/arith_sequencer_fifo.sv | 66 ++++++
 rtl/arith_sequencer.sv | 141 ++++++++++++++
 tb/tb_arith_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_sequencer_pkg.sv
// rtl/arith_sequencer_pkg.sv - opcode/funct/ALU encodings, FSM states and instruction decode helper
package arith_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [1:0] SRC2_RT   = 2'b00;
  localparam logic [1:0] SRC2_SEXT = 2'b01;
  localparam logic [1:0] SRC2_ZEXT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       rd_src;
    logic [1:0] alu_src2;
    logic [2:0] alu_op;
  } dec_t;

  // Map opcode/funct onto control fields; anything unlisted is illegal.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.legal    = 1'b1;
    d.rd_src   = 1'b1;
    d.alu_src2 = SRC2_ZEXT;
    d.alu_op   = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        d.rd_src   = 1'b0;
        d.alu_src2 = SRC2_RT;
        case (funct)
          FN_ADD:  d.alu_op = ALU_ADD;
          FN_SUB:  d.alu_op = ALU_SUB;
          FN_AND:  d.alu_op = ALU_AND;
          FN_OR:   d.alu_op = ALU_OR;
          FN_NOR:  d.alu_op = ALU_NOR;
          FN_XOR:  d.alu_op = ALU_XOR;
          default: d.legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.alu_op   = ALU_ADD;
        d.alu_src2 = SRC2_SEXT;
      end
      OP_ANDI: d.alu_op = ALU_AND;
      OP_ORI:  d.alu_op = ALU_OR;
      OP_XORI: d.alu_op = ALU_XOR;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/arith_sequencer_fifo.sv
// rtl/arith_sequencer_fifo.sv - instruction FIFO, pointer+count, synchronous flush
module arith_sequencer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // full comes only from the registered count, so a same-cycle pop never frees a slot
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next pointers and occupancy; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/arith_sequencer.sv
// rtl/arith_sequencer.sv - instruction queue, decoder, RUN/HALT FSM and registered control outputs
module arith_sequencer
  import arith_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  input  logic             run,
  input  logic             clear,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic             rd_src,
  output logic             wr_enable,
  output logic [1:0]       alu_src2,
  output logic [2:0]       alu_op,
  output logic [15:0]      imm16,
  output logic             halted,
  output logic             err,
  output logic [31:0]      bad_instr,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic               rd_src_q, rd_src_d;
  logic               wr_enable_q, wr_enable_d;
  logic [1:0]         alu_src2_q, alu_src2_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [15:0]        imm16_q, imm16_d;
  logic               err_q, err_d;
  logic [31:0]        bad_instr_q, bad_instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [31:0] head;
  logic        empty, full, pop;
  dec_t        dec;

  arith_sequencer_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (in_valid),
    .push_data (in_instr),
    .pop       (pop),
    .flush     (clear),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  assign in_ready = !full;
  assign dec      = decode(head[31:26], head[5:0]);
  // clear flushes the queue this edge, so it must not also consume the head
  assign pop      = (state_q == ST_RUN) && run && !empty && !clear;

  // Next state and next control fields; fields hold unless a legal instruction issues.
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    rd_src_d    = rd_src_q;
    alu_src2_d  = alu_src2_q;
    alu_op_d    = alu_op_q;
    imm16_d     = imm16_q;
    wr_enable_d = 1'b0;
    err_d       = err_q;
    bad_instr_d = bad_instr_q;
    retired_d   = retired_q;
    if (clear) begin
      state_d = ST_RUN;
      err_d   = 1'b0;
    end else if (pop) begin
      if (dec.legal) begin
        rs_d        = head[25:21];
        rt_d        = head[20:16];
        rd_d        = head[15:11];
        imm16_d     = head[15:0];
        rd_src_d    = dec.rd_src;
        alu_src2_d  = dec.alu_src2;
        alu_op_d    = dec.alu_op;
        wr_enable_d = 1'b1;
        retired_d   = retired_q + CNT_W'(1);
      end else begin
        state_d     = ST_HALT;
        err_d       = 1'b1;
        bad_instr_d = head;
      end
    end
  end

  // State and output registers; async reset zeroes every output immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rd_src_q    <= 1'b0;
      alu_src2_q  <= '0;
      alu_op_q    <= '0;
      imm16_q     <= '0;
      wr_enable_q <= 1'b0;
      err_q       <= 1'b0;
      bad_instr_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rd_src_q    <= rd_src_d;
      alu_src2_q  <= alu_src2_d;
      alu_op_q    <= alu_op_d;
      imm16_q     <= imm16_d;
      wr_enable_q <= wr_enable_d;
      err_q       <= err_d;
      bad_instr_q <= bad_instr_d;
      retired_q   <= retired_d;
    end
  end

  assign rs        = rs_q;
  assign rt        = rt_q;
  assign rd        = rd_q;
  assign rd_src    = rd_src_q;
  assign alu_src2  = alu_src2_q;
  assign alu_op    = alu_op_q;
  assign imm16     = imm16_q;
  assign wr_enable = wr_enable_q;
  assign err       = err_q;
  assign bad_instr = bad_instr_q;
  assign retired   = retired_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_arith_sequencer.sv
// tb/tb_arith_sequencer.sv - directed self-checking bench for arith_sequencer with a small regfile/ALU model
module tb_arith_sequencer;

  logic        clock, reset, in_valid, in_ready, run, clear;
  logic [31:0] in_instr, bad_instr;
  logic [4:0]  rs, rt, rd;
  logic        rd_src, wr_enable, halted, err;
  logic [1:0]  alu_src2;
  logic [2:0]  alu_op;
  logic [15:0] imm16, retired;

  logic [31:0] regs [32];
  int total = 0;
  int bad   = 0;

  arith_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .run       (run),
    .clear     (clear),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .rd_src    (rd_src),
    .wr_enable (wr_enable),
    .alu_src2  (alu_src2),
    .alu_op    (alu_op),
    .imm16     (imm16),
    .halted    (halted),
    .err       (err),
    .bad_instr (bad_instr),
    .retired   (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // arith_machine stand-in: executes the presented controls mid-cycle
  always @(negedge clock) begin
    logic [31:0] a, b, r;
    logic [4:0]  dst;
    if (wr_enable) begin
      a = regs[rs];
      case (alu_src2)
        2'b01:   b = {{16{imm16[15]}}, imm16};
        2'b10:   b = {16'h0000, imm16};
        default: b = regs[rt];
      endcase
      case (alu_op)
        3'b010:  r = a + b;
        3'b011:  r = a - b;
        3'b100:  r = a & b;
        3'b101:  r = a | b;
        3'b110:  r = ~(a | b);
        default: r = a ^ b;
      endcase
      dst = rd_src ? rt : rd;
      if (dst != 5'd0) regs[dst] = r;
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    reset = 1'b0; in_valid = 1'b0; in_instr = 32'h0; run = 1'b0; clear = 1'b0;
    tick(); tick();
    expect_eq("rst_in_ready", in_ready, 1);
    expect_eq("rst_we", wr_enable, 0);
    expect_eq("rst_halted", halted, 0);
    expect_eq("rst_err", err, 0);
    expect_eq("rst_retired", retired, 0);
    expect_eq("rst_bad", bad_instr, 0);
    expect_eq("rst_op", alu_op, 0);
    reset = 1'b1;
    tick();

    // 1: addi $1,$0,0xaaa
    run = 1'b1; in_valid = 1'b1; in_instr = 32'h20010aaa;
    tick();
    in_valid = 1'b0;
    expect_eq("t1_latency", wr_enable, 0);
    tick();
    expect_eq("t1_we", wr_enable, 1);
    expect_eq("t1_rt", rt, 1);
    expect_eq("t1_rd_src", rd_src, 1);
    expect_eq("t1_alu_op", alu_op, 3'b010);
    expect_eq("t1_src2", alu_src2, 2'b01);
    expect_eq("t1_imm", imm16, 16'h0aaa);
    expect_eq("t1_retired", retired, 1);
    tick();
    expect_eq("t1_we_drop", wr_enable, 0);
    expect_eq("t1_r1", regs[1], 32'h00000aaa);

    // 2: ori $5,$1,5 then xor $6,$1,$5 back to back
    in_valid = 1'b1; in_instr = 32'h34250005;
    tick();
    in_instr = 32'h00253026;
    tick();
    in_valid = 1'b0;
    expect_eq("t2_we0", wr_enable, 1);
    expect_eq("t2_op0", alu_op, 3'b101);
    expect_eq("t2_src2_0", alu_src2, 2'b10);
    tick();
    expect_eq("t2_we1", wr_enable, 1);
    expect_eq("t2_op1", alu_op, 3'b111);
    expect_eq("t2_rd", rd, 6);
    expect_eq("t2_rd_src", rd_src, 0);
    expect_eq("t2_src2_1", alu_src2, 2'b00);
    tick();
    expect_eq("t2_idle", wr_enable, 0);
    expect_eq("t2_r5", regs[5], 32'h00000aaf);
    expect_eq("t2_r6", regs[6], 32'h00000005);
    expect_eq("t2_retired", retired, 3);

    // 3: fill with run=0, 5th word held off, then drain
    run = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = 32'h00211020;
      tick();
    end
    expect_eq("t3_full", in_ready, 0);
    in_instr = 32'h20020001;
    tick();
    expect_eq("t3_hold_ready", in_ready, 0);
    expect_eq("t3_stall_we", wr_enable, 0);
    in_valid = 1'b0; run = 1'b1;
    tick();
    expect_eq("t3_pop0", wr_enable, 1);
    expect_eq("t3_ready_back", in_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_eq($sformatf("t3_pop%0d", i), wr_enable, 1);
    end
    tick();
    expect_eq("t3_no_5th", wr_enable, 0);
    expect_eq("t3_retired", retired, 7);
    expect_eq("t3_r2", regs[2], 32'h00001554);

    // 4: illegal opcode between two adds
    run = 1'b0; in_valid = 1'b1;
    in_instr = 32'h00211020; tick();
    in_instr = 32'hfc000000; tick();
    in_instr = 32'h00411820; tick();
    in_valid = 1'b0; run = 1'b1;
    tick();
    expect_eq("t4_first_add", wr_enable, 1);
    tick();
    expect_eq("t4_ill_we", wr_enable, 0);
    expect_eq("t4_err", err, 1);
    expect_eq("t4_halted", halted, 1);
    expect_eq("t4_bad", bad_instr, 32'hfc000000);
    tick();
    expect_eq("t4_no_second", wr_enable, 0);
    expect_eq("t4_still_halted", halted, 1);
    expect_eq("t4_retired", retired, 8);
    clear = 1'b1; tick(); clear = 1'b0;
    expect_eq("t4_clr_halted", halted, 0);
    expect_eq("t4_clr_err", err, 0);
    expect_eq("t4_clr_ready", in_ready, 1);
    tick(); tick();
    expect_eq("t4_flushed_we", wr_enable, 0);
    expect_eq("t4_flushed_ret", retired, 8);
    expect_eq("t4_r3", regs[3], 0);
    // illegal R-type funct (addu)
    in_valid = 1'b1; in_instr = 32'h00221821; tick();
    in_valid = 1'b0; tick();
    expect_eq("t4_funct_halt", halted, 1);
    expect_eq("t4_funct_bad", bad_instr, 32'h00221821);
    expect_eq("t4_funct_ret", retired, 8);
    clear = 1'b1; tick(); clear = 1'b0;
    expect_eq("t4_funct_clr", halted, 0);

    // 5: retired wrap
    reset = 1'b0; tick(); reset = 1'b1; tick();
    expect_eq("t5_ret0", retired, 0);
    run = 1'b1; in_valid = 1'b1; in_instr = 32'h00000020;
    repeat (65534) tick();
    in_valid = 1'b0;
    tick();
    expect_eq("t5_fffe", retired, 16'hfffe);
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    expect_eq("t5_ffff", retired, 16'hffff);
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    expect_eq("t5_wrap0", retired, 16'h0000);
    in_valid = 1'b1; tick(); in_valid = 1'b0; tick();
    expect_eq("t5_wrap1", retired, 16'h0001);

    // 6: async reset mid-issue
    in_valid = 1'b1; in_instr = 32'h00211020; tick();
    in_instr = 32'h20030bbb; tick();
    in_valid = 1'b0;
    expect_eq("t6_pre_we", wr_enable, 1);
    #2 reset = 1'b0;
    #1;
    expect_eq("t6_async_we", wr_enable, 0);
    expect_eq("t6_async_rd", rd, 0);
    expect_eq("t6_async_ret", retired, 0);
    #1 reset = 1'b1;
    tick(); tick();
    expect_eq("t6_queue_lost", wr_enable, 0);
    in_valid = 1'b1; in_instr = 32'h20040123; tick();
    in_valid = 1'b0; tick();
    expect_eq("t6_first_we", wr_enable, 1);
    expect_eq("t6_first_rt", rt, 4);
    expect_eq("t6_first_imm", imm16, 16'h0123);
    expect_eq("t6_first_ret", retired, 1);
    tick();
    expect_eq("t6_r4", regs[4], 32'h00000123);
    expect_eq("t6_r3_untouched", regs[3], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
